reg_text_writer: RTL and testbench



---
 rtl/text_writer_pkg.sv | 42 ++++
 rtl/char_fmt.sv | 65 ++++++
 rtl/reg_text_writer.sv | 216 +++++++++++++++++++++
 tb/tb_reg_text_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_writer_pkg.sv
// Shared definitions for the register-dump text writer: FSM encoding,
// ASCII constants and the header string ROM.
package text_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_SNAP   = 3'd2,
        ST_LINE   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_R     = 8'h52;

    localparam int HDR_TEXT_LEN = 21;
    localparam logic [8*HDR_TEXT_LEN-1:0] HDR_TEXT_HEX = "REGISTER VALUES (HEX)";
    localparam logic [8*HDR_TEXT_LEN-1:0] HDR_TEXT_BIN = "REGISTER VALUES (BIN)";

    // Header character at position pos; anything past the text is a space.
    function automatic logic [7:0] header_char(input int pos, input logic hex);
        logic [8*HDR_TEXT_LEN-1:0] txt;
        logic [7:0]                res;
        txt = hex ? HDR_TEXT_HEX : HDR_TEXT_BIN;
        res = CH_SPACE;
        for (int k = 0; k < HDR_TEXT_LEN; k++) begin
            res = (pos == k) ? txt[8*(HDR_TEXT_LEN-1-k) +: 8] : res;
        end
        return res;
    endfunction

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (CH_ZERO + {4'h0, nib})
                             : (CH_A + {4'h0, nib} - 8'd10);
    endfunction

endpackage

// File: rtl/char_fmt.sv
// Combinational formatter for one character of a register line:
// "Rnn: " prefix followed by hex or binary digits, MSB first.
module char_fmt
    import text_writer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int POS_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic              mode_hex,
    input  logic [POS_W-1:0]  pos,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] snap,
    output logic [7:0]        ascii
);

    localparam int NIBBLES = DATA_W / 4;

    logic [6:0] idx7_s;
    logic [6:0] tens_s;
    logic [6:0] units_s;
    int         digit_s;
    logic [3:0] nib_s;
    logic       bit_s;

    // Decimal split of the register index (index is always below 100).
    always_comb begin
        idx7_s  = 7'(idx);
        tens_s  = idx7_s / 7'd10;
        units_s = idx7_s % 7'd10;
    end

    // Digit position after the 5-character prefix selects a nibble or a bit.
    always_comb begin
        digit_s = int'(pos) - 32'sd5;
        nib_s   = 4'h0;
        bit_s   = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            nib_s = nib_s | ((digit_s == k) ? snap[DATA_W-4-4*k +: 4] : 4'h0);
        end
        for (int k = 0; k < DATA_W; k++) begin
            bit_s = bit_s | ((digit_s == k) ? snap[DATA_W-1-k] : 1'b0);
        end
    end

    // Character mux; hex lines are padded with spaces to the binary width.
    always_comb begin
        ascii = CH_SPACE;
        case (pos)
            POS_W'(0): ascii = CH_R;
            POS_W'(1): ascii = CH_ZERO + {1'b0, tens_s};
            POS_W'(2): ascii = CH_ZERO + {1'b0, units_s};
            POS_W'(3): ascii = CH_COLON;
            POS_W'(4): ascii = CH_SPACE;
            default: begin
                if (mode_hex) begin
                    ascii = (digit_s < NIBBLES) ? nib_ascii(nib_s) : CH_SPACE;
                end else begin
                    ascii = bit_s ? CH_ONE : CH_ZERO;
                end
            end
        endcase
    end

endmodule

// File: rtl/reg_text_writer.sv
// Register-dump text writer: writes a header line and one formatted line
// per register into the VGA character RAM through a ready handshake.
module reg_text_writer
    import text_writer_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_W       = 32,
    parameter int COLS         = 80,
    parameter int ROWS         = 40,
    parameter int MARGIN_LEFT  = 5,
    parameter int FIRST_ROW    = 2,
    parameter int ADDR_W       = 12,
    parameter int AUTO_REFRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic                       mode_hex,
    input  logic                       refresh_req,
    input  logic                       text_ready,
    output logic [7:0]                 text_data,
    output logic [ADDR_W-1:0]          text_addr,
    output logic                       text_we,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int LINE_LEN = 5 + DATA_W;
    localparam int HDR_LEN  = COLS - MARGIN_LEFT;
    localparam int MAX_LEN  = (HDR_LEN > LINE_LEN) ? HDR_LEN : LINE_LEN;
    localparam int POS_W    = $clog2(MAX_LEN);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int AW1      = ADDR_W + 1;

    if (NUM_REGS < 1 || NUM_REGS > 99) begin : g_chk_num_regs
        $fatal(1, "reg_text_writer: NUM_REGS must be 1..99");
    end
    if (DATA_W < 4 || DATA_W > 64 || (DATA_W % 4) != 0) begin : g_chk_data_w
        $fatal(1, "reg_text_writer: DATA_W must be 4..64 and a multiple of 4");
    end
    if (FIRST_ROW + NUM_REGS > ROWS) begin : g_chk_rows
        $fatal(1, "reg_text_writer: register lines do not fit on screen");
    end
    if (MARGIN_LEFT + LINE_LEN > COLS) begin : g_chk_cols
        $fatal(1, "reg_text_writer: register line wider than screen");
    end
    if (COLS * ROWS > 2**ADDR_W) begin : g_chk_addr
        $fatal(1, "reg_text_writer: ADDR_W too small for screen");
    end

    state_t              state_r,  state_nx_s;
    logic [POS_W-1:0]    pos_r,    pos_nx_s;
    logic [IDX_W-1:0]    idx_r,    idx_nx_s;
    logic [DATA_W-1:0]   snap_r,   snap_nx_s;
    logic                mode_r,   mode_nx_s;
    logic [DATA_W-1:0]   reg_sel_s;
    logic                accept_s;
    logic [7:0]          fmt_char_s;

    logic                we_nx_s, busy_nx_s, done_nx_s;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic [7:0]          data_nx_s;

    logic                text_we_r, busy_r, frame_done_r;
    logic [ADDR_W-1:0]   text_addr_r;
    logic [7:0]          text_data_r;

    assign accept_s = text_we_r & text_ready;

    // Register addressed by the current line index.
    always_comb begin
        reg_sel_s = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_sel_s = reg_sel_s | ((int'(idx_r) == k) ? regs_flat[k*DATA_W +: DATA_W] : '0);
        end
    end

    // Next-state logic; pos/idx only advance on an accepted character.
    always_comb begin
        state_nx_s = state_r;
        pos_nx_s   = pos_r;
        idx_nx_s   = idx_r;
        snap_nx_s  = snap_r;
        mode_nx_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if ((AUTO_REFRESH != 0) || refresh_req) begin
                    state_nx_s = ST_HEADER;
                    pos_nx_s   = '0;
                    idx_nx_s   = '0;
                    mode_nx_s  = mode_hex;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (accept_s) begin
                    if (pos_r == POS_W'(HDR_LEN - 1)) begin
                        state_nx_s = ST_SNAP;
                        pos_nx_s   = '0;
                        idx_nx_s   = '0;
                    end else begin
                        pos_nx_s = pos_r + POS_W'(1);
                    end
                end else begin
                    state_nx_s = ST_HEADER;
                end
            end
            ST_SNAP: begin
                snap_nx_s  = reg_sel_s;
                state_nx_s = ST_LINE;
                pos_nx_s   = '0;
            end
            ST_LINE: begin
                if (accept_s) begin
                    if (pos_r == POS_W'(LINE_LEN - 1)) begin
                        pos_nx_s = '0;
                        if (idx_r == IDX_W'(NUM_REGS - 1)) begin
                            state_nx_s = ST_DONE;
                        end else begin
                            idx_nx_s   = idx_r + IDX_W'(1);
                            state_nx_s = ST_SNAP;
                        end
                    end else begin
                        pos_nx_s = pos_r + POS_W'(1);
                    end
                end else begin
                    state_nx_s = ST_LINE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    char_fmt #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W),
        .IDX_W  (IDX_W)
    ) u_char_fmt (
        .mode_hex (mode_nx_s),
        .pos      (pos_nx_s),
        .idx      (idx_nx_s),
        .snap     (snap_nx_s),
        .ascii    (fmt_char_s)
    );

    // Outputs for the next cycle, derived from the next state so they can be registered.
    always_comb begin
        we_nx_s   = (state_nx_s == ST_HEADER) || (state_nx_s == ST_LINE);
        busy_nx_s = (state_nx_s != ST_IDLE);
        done_nx_s = (state_nx_s == ST_DONE);
        addr_nx_s = '0;
        data_nx_s = CH_SPACE;
        case (state_nx_s)
            ST_HEADER: begin
                addr_nx_s = ADDR_W'(AW1'(MARGIN_LEFT) + AW1'(pos_nx_s));
                data_nx_s = header_char(int'(pos_nx_s), mode_nx_s);
            end
            ST_LINE: begin
                addr_nx_s = ADDR_W'((AW1'(FIRST_ROW) + AW1'(idx_nx_s)) * AW1'(COLS)
                                    + AW1'(MARGIN_LEFT) + AW1'(pos_nx_s));
                data_nx_s = fmt_char_s;
            end
            default: begin
                addr_nx_s = '0;
                data_nx_s = CH_SPACE;
            end
        endcase
    end

    // FSM and datapath state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            pos_r   <= '0;
            idx_r   <= '0;
            snap_r  <= '0;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pos_r   <= pos_nx_s;
            idx_r   <= idx_nx_s;
            snap_r  <= snap_nx_s;
            mode_r  <= mode_nx_s;
        end
    end

    // Output registers; they hold their value while a write is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_we_r    <= 1'b0;
            text_data_r  <= CH_SPACE;
            text_addr_r  <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            text_we_r    <= we_nx_s;
            text_data_r  <= data_nx_s;
            text_addr_r  <= addr_nx_s;
            busy_r       <= busy_nx_s;
            frame_done_r <= done_nx_s;
        end
    end

    assign text_we    = text_we_r;
    assign text_data  = text_data_r;
    assign text_addr  = text_addr_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_reg_text_writer.sv
// Randomized bench for reg_text_writer: every frame's write log is compared
// against screen text built with string formatting from the display rules.
module tb_reg_text_writer;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TC = 20;
    localparam int TR = 8;
    localparam int ML = 2;
    localparam int FR = 2;
    localparam int AW = 8;
    localparam int LL = 5 + DW;
    localparam int HL = TC - ML;

    typedef logic [AW+7:0] wr_t;

    logic            clk;
    logic            reset_n;
    logic [NR*DW-1:0] regs_v;
    logic            mode_hex;
    logic            refresh_req;
    logic            text_ready;
    logic [7:0]      text_data;
    logic [AW-1:0]   text_addr;
    logic            text_we;
    logic            busy;
    logic            frame_done;

    logic            refresh_a;
    logic            ready_a;
    logic [7:0]      text_data_a;
    logic [AW-1:0]   text_addr_a;
    logic            text_we_a;
    logic            busy_a;
    logic            frame_done_a;

    int  tests_run;
    int  tests_failed;
    wr_t log_q[$];

    reg_text_writer #(
        .NUM_REGS(NR), .DATA_W(DW), .COLS(TC), .ROWS(TR), .MARGIN_LEFT(ML),
        .FIRST_ROW(FR), .ADDR_W(AW), .AUTO_REFRESH(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .regs_flat(regs_v), .mode_hex(mode_hex),
        .refresh_req(refresh_req), .text_ready(text_ready), .text_data(text_data),
        .text_addr(text_addr), .text_we(text_we), .busy(busy), .frame_done(frame_done)
    );

    reg_text_writer #(
        .NUM_REGS(NR), .DATA_W(DW), .COLS(TC), .ROWS(TR), .MARGIN_LEFT(ML),
        .FIRST_ROW(FR), .ADDR_W(AW), .AUTO_REFRESH(1)
    ) dut_auto (
        .clk(clk), .reset_n(reset_n), .regs_flat(regs_v), .mode_hex(mode_hex),
        .refresh_req(refresh_a), .text_ready(ready_a), .text_data(text_data_a),
        .text_addr(text_addr_a), .text_we(text_we_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference screen: header then one line per register, in write order.
    task automatic compare_log(input string tag, input logic hex, input logic [NR*DW-1:0] rv);
        wr_t   exp_q[$];
        string hdr;
        string line;
        logic [7:0] ch;
        hdr = hex ? "REGISTER VALUES (HEX)" : "REGISTER VALUES (BIN)";
        for (int c = 0; c < HL; c++) begin
            ch = (c < hdr.len()) ? hdr[c] : 8'h20;
            exp_q.push_back({AW'(ML + c), ch});
        end
        for (int i = 0; i < NR; i++) begin
            if (hex) line = $sformatf("R%02d: %02h", i, rv[i*DW +: DW]);
            else     line = $sformatf("R%02d: %08b", i, rv[i*DW +: DW]);
            line = line.toupper();
            for (int c = 0; c < LL; c++) begin
                ch = (c < line.len()) ? line[c] : 8'h20;
                exp_q.push_back({AW'((FR + i) * TC + ML + c), ch});
            end
        end
        check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_wr%0d_addr%0d", tag, i, int'(exp_q[i][AW+7:8])),
                  64'(log_q[i]), 64'(exp_q[i]));
        end
    endtask

    // Trigger one frame and log accepted writes; returns frame length in cycles
    // counting the request cycle as cycle 1 and the frame_done cycle as the last.
    task automatic run_frame(input logic hex, input logic bp, input logic snap_mod, output int len);
        int            cyc;
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        logic [7:0]    prev_data;
        log_q.delete();
        len = -1;
        @(posedge clk); #1;
        mode_hex    = hex;
        refresh_req = 1'b1;
        text_ready  = 1'b1;
        @(negedge clk);
        cyc        = 1;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            mode_hex    = 1'($urandom);
            refresh_req = ($urandom_range(0, 15) == 0);
            text_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            @(negedge clk);
            if (prev_stall) begin
                check("stall_we_held", 64'(text_we), 64'd1);
                check("stall_addr_held", 64'(text_addr), 64'(prev_addr));
                check("stall_data_held", 64'(text_data), 64'(prev_data));
            end
            if (text_we && text_ready) log_q.push_back({text_addr, text_data});
            prev_stall = text_we && !text_ready;
            prev_addr  = text_addr;
            prev_data  = text_data;
            if (snap_mod && text_we && int'(text_addr) == (FR + 1) * TC + ML + 3)
                regs_v[1*DW +: DW] = 8'hFF;
            if (frame_done) begin
                len = cyc;
                break;
            end
        end
        refresh_req = 1'b0;
        text_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("no_queued_refresh", 64'(busy), 64'd0);
    endtask

    initial begin
        int               len;
        int               n;
        logic             found;
        logic [NR*DW-1:0] saved;
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        regs_v       = '0;
        mode_hex     = 1'b0;
        refresh_req  = 1'b0;
        text_ready   = 1'b1;
        refresh_a    = 1'b0;
        ready_a      = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_we", 64'(text_we), 64'd0);
        check("rst_data", 64'(text_data), 64'h20);
        check("rst_addr", 64'(text_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_auto_busy", 64'(busy_a), 64'd0);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_trigger", 64'(busy), 64'd0);

        regs_v = $urandom;
        regs_v[2*DW +: DW] = 8'hA5;
        saved = regs_v;
        run_frame(1'b0, 1'b0, 1'b0, len);
        check("bin_frame_len", 64'(len), 64'd76);
        compare_log("bin", 1'b0, saved);

        run_frame(1'b1, 1'b0, 1'b0, len);
        check("hex_frame_len", 64'(len), 64'd76);
        compare_log("hex", 1'b1, saved);

        for (int r = 0; r < 3; r++) begin
            regs_v = $urandom;
            saved  = regs_v;
            run_frame(1'(r), 1'b1, 1'b0, len);
            check("bp_frame_finished", 64'(len > 76), 64'd1);
            compare_log($sformatf("bp%0d", r), 1'(r), saved);
        end

        regs_v = $urandom;
        regs_v[1*DW +: DW] = 8'h00;
        saved = regs_v;
        run_frame(1'b0, 1'b0, 1'b1, len);
        compare_log("snap_old", 1'b0, saved);
        saved = regs_v;
        check("snap_reg_changed", 64'(saved[1*DW +: DW]), 64'hFF);
        run_frame(1'b0, 1'b0, 1'b0, len);
        compare_log("snap_new", 1'b0, saved);

        @(posedge clk); #1;
        mode_hex    = 1'b0;
        refresh_req = 1'b1;
        @(posedge clk); #1;
        refresh_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            found = text_we && (int'(text_addr) >= (FR + 3) * TC + ML + 4);
        end
        check("reached_reg3_line", 64'(found), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_we", 64'(text_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data", 64'(text_data), 64'h20);
        check("abort_addr", 64'(text_addr), 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        regs_v = $urandom;
        saved  = regs_v;
        run_frame(1'b1, 1'b0, 1'b0, len);
        check("after_reset_first_addr", 64'(log_q.size() > 0 ? int'(log_q[0][AW+7:8]) : -1), 64'd2);
        check("after_reset_len", 64'(len), 64'd76);
        compare_log("after_reset", 1'b1, saved);

        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = frame_done_a;
        end
        check("auto_first_done", 64'(found), 64'd1);
        for (int f = 0; f < 3; f++) begin
            n     = 0;
            found = 1'b0;
            while (n < 300 && !found) begin
                @(posedge clk); #1;
                refresh_a = (n == 20) || (n == 50);
                @(negedge clk);
                n++;
                if (n == 21) check("auto_busy_at_req", 64'(busy_a), 64'd1);
                found = frame_done_a;
            end
            refresh_a = 1'b0;
            check($sformatf("auto_period%0d", f), 64'(n), 64'd76);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
